// File: rtl/seq_detect_param.sv
// Parametrised serial bit-sequence detector with a runtime-loadable pattern,
// overlapping/non-overlapping modes, an input-valid qualifier and a saturating match counter.
module seq_detect_param #(
  parameter int               W       = 8,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [W-1:0]     DEF_PAT = 8'b0001_0100,
  parameter logic [LEN_W-1:0] DEF_LEN = LEN_W'(5),
  parameter logic             DEF_OVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [W-1:0]     pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             ovl_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0]     hist, hist_nx, pat, mask;
  logic [LEN_W-1:0] fill, fill_nx, len, len_clamp;
  logic             ovl, hit;

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    hist_nx   = {hist[W-2:0], x};
    fill_nx   = (fill == LEN_MAX) ? LEN_MAX : fill + 1'b1;
    len_clamp = (len_in == '0 || len_in > LEN_MAX) ? LEN_MAX : len_in;
    mask      = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    // Only the low len bits of the history take part; the rest are don't-care.
    hit = en && !load && (fill_nx >= len) && (((hist_nx ^ pat) & mask) == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= DEF_PAT;
      len       <= DEF_LEN;
      ovl       <= DEF_OVL;
      z         <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (load) begin
        pat  <= pat_in;
        len  <= len_clamp;
        ovl  <= ovl_in;
        hist <= '0;
        fill <= '0;
        z    <= 1'b0;
      end else if (en) begin
        hist <= hist_nx;
        // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
        fill <= (hit && !ovl) ? '0 : fill_nx;
        z    <= hit;
      end else begin
        z <= 1'b0;
      end

      if (cnt_clr) begin
        match_cnt <= '0;
      end else if (hit && match_cnt != CNT_MAX) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios plus a random run,
// compared against a queue-based model of the valid-bit stream.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst, en, x, load, ovl_in, cnt_clr;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       z, z2;
  logic [7:0] match_cnt;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         hq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         exp_z;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .len_in(len_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr), .z(z), .match_cnt(match_cnt)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .len_in(len_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr), .z(z2), .match_cnt(cnt2)
  );

  always #5 clk = ~clk;

  // Last m_len valid bits (newest last in the queue) must equal pat[m_len-1:0], pat bit 0 newest.
  function automatic bit model_match();
    if (hq.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      if (hq[hq.size() - 1 - i] != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit outputs_ok();
    return (z === exp_z) && (z2 === exp_z) && (match_cnt === m_cnt) && (cnt2 === m_cnt2);
  endfunction

  // Drive one clock of stimulus, advance the model at the edge, settle 1 time unit after it.
  task automatic cycle(input bit r, input bit l, input bit e, input bit xx, input bit clr);
    bit m;
    rst = r; load = l; en = e; x = xx; cnt_clr = clr;
    @(posedge clk);
    m = 1'b0;
    if (rst) begin
      hq.delete();
      m_pat = 8'b0001_0100; m_len = 5; m_ovl = 1'b1;
      exp_z = 1'b0; m_cnt = '0; m_cnt2 = '0;
    end else begin
      if (load) begin
        hq.delete();
        m_pat = pat_in;
        m_len = (len_in == 0 || len_in > 8) ? 8 : int'(len_in);
        m_ovl = ovl_in;
        exp_z = 1'b0;
      end else if (en) begin
        hq.push_back(x);
        if (hq.size() > 8) void'(hq.pop_front());
        m = model_match();
        if (m && !m_ovl) hq.delete();
        exp_z = m;
      end else begin
        exp_z = 1'b0;
      end
      if (cnt_clr) begin
        m_cnt = '0; m_cnt2 = '0;
      end else if (m) begin
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 1'b1;
        if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 1'b1;
      end
    end
    #1;
    rst = 1'b0; load = 1'b0; en = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic sample(input bit b);
    cycle(1'b0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input bit o);
    pat_in = p; len_in = l; ovl_in = o;
    cycle(1'b0, 1'b1, 1'b1, 1'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'($urandom), 1'b1, 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    pat_in = 8'hFF; len_in = 4'd1; ovl_in = 1'b0;
    do_reset();
    do_reset();
    checks++;
    if (z !== 1'b0 || match_cnt !== 8'd0 || cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL reset: z=%0b cnt=%0d cnt2=%0d, want z=0 cnt=0 cnt2=0", z, match_cnt, cnt2);
    end
  endtask

  task automatic test_default_pattern();
    logic [4:0] s = 5'b10100;
    for (int rep = 0; rep < 2; rep++) begin
      logic [4:0] hits = '0;
      for (int i = 0; i < 5; i++) begin
        sample(s[4 - i]);
        hits[4 - i] = z;
        checks++;
        if (!outputs_ok()) begin
          errors++;
          $display("FAIL default bit%0d: z=%0b cnt=%0d, want z=%0b cnt=%0d", i, z, match_cnt, exp_z, m_cnt);
        end
      end
      checks++;
      if (hits !== 5'b00001 || match_cnt !== 8'(rep + 1)) begin
        errors++;
        $display("FAIL default_pulses rep%0d: hits=%b cnt=%0d, want hits=00001 cnt=%0d", rep, hits, match_cnt, rep + 1);
      end
    end
  endtask

  task automatic test_overlap();
    logic [4:0] s = 5'b10101;
    for (int o = 1; o >= 0; o--) begin
      logic [4:0] hits = '0;
      logic [7:0] base;
      do_load(8'b0000_0101, 4'd3, 1'(o));
      base = match_cnt;
      for (int i = 0; i < 5; i++) begin
        sample(s[4 - i]);
        hits[4 - i] = z;
        checks++;
        if (!outputs_ok()) begin
          errors++;
          $display("FAIL overlap%0d bit%0d: z=%0b cnt=%0d, want z=%0b cnt=%0d", o, i, z, match_cnt, exp_z, m_cnt);
        end
      end
      checks++;
      if (hits !== (o ? 5'b00101 : 5'b00100) || match_cnt !== base + 8'(o ? 2 : 1)) begin
        errors++;
        $display("FAIL overlap%0d_pulses: hits=%b cnt=%0d, want hits=%b cnt=%0d", o, hits, match_cnt,
                 o ? 5'b00101 : 5'b00100, base + 8'(o ? 2 : 1));
      end
    end
  endtask

  task automatic test_en_gaps();
    logic [4:0] s = 5'b10100;
    int pulses = 0;
    do_load(8'b0001_0100, 4'd5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) sample(s[4 - i / 2]);
      else cycle(1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0);
      pulses += int'(z);
      checks++;
      if (!outputs_ok()) begin
        errors++;
        $display("FAIL en_gap cyc%0d: z=%0b cnt=%0d, want z=%0b cnt=%0d", i, z, match_cnt, exp_z, m_cnt);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL en_gap_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_midstream();
    for (int k = 0; k < 2; k++) begin
      int pulses = 0;
      sample(1'b1); sample(1'b0); sample(1'b1);
      if (k == 0) do_load(8'b0001_0100, 4'd5, 1'b1);
      else do_reset();
      sample(1'b0); pulses += int'(z);
      sample(1'b0); pulses += int'(z);
      checks++;
      if (pulses != 0 || !outputs_ok()) begin
        errors++;
        $display("FAIL midstream_%s: pulses=%0d z=%0b cnt=%0d, want pulses=0 cnt=%0d",
                 k == 0 ? "load" : "rst", pulses, z, match_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_len_clamp();
    logic [7:0] s = 8'hA5;
    for (int n = 8; n >= 7; n--) begin
      int pulses = 0;
      do_load(8'hA5, 4'd0, 1'b1);
      for (int i = 0; i < n; i++) begin
        sample(s[7 - i]);
        pulses += int'(z);
        checks++;
        if (!outputs_ok()) begin
          errors++;
          $display("FAIL clamp%0d bit%0d: z=%0b cnt=%0d, want z=%0b cnt=%0d", n, i, z, match_cnt, exp_z, m_cnt);
        end
      end
      checks++;
      if (pulses != (n == 8 ? 1 : 0)) begin
        errors++;
        $display("FAIL clamp%0d_pulses: got %0d want %0d", n, pulses, n == 8 ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    do_reset();
    do_load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sample(1'b1);
      pulses += int'(z2);
      checks++;
      if (!outputs_ok()) begin
        errors++;
        $display("FAIL sat bit%0d: z2=%0b cnt2=%0d, want z2=%0b cnt2=%0d", i, z2, cnt2, exp_z, m_cnt2);
      end
    end
    checks++;
    if (pulses != 5 || cnt2 !== 2'd3 || match_cnt !== 8'd5) begin
      errors++;
      $display("FAIL sat_final: pulses=%0d cnt2=%0d cnt=%0d, want 5/3/5", pulses, cnt2, match_cnt);
    end
  endtask

  task automatic test_cnt_clr();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (z !== 1'b1 || match_cnt !== 8'd0 || cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_clr: z=%0b cnt=%0d cnt2=%0d, want z=1 cnt=0 cnt2=0", z, match_cnt, cnt2);
    end
    sample(1'b1);
    checks++;
    if (z !== 1'b1 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL cnt_after_clr: z=%0b cnt=%0d, want z=1 cnt=1", z, match_cnt);
    end
  endtask

  task automatic test_long_pattern();
    logic [11:0] s = 12'b1100_1100_1100;
    for (int o = 1; o >= 0; o--) begin
      logic [11:0] hits = '0;
      do_load(8'b1100_1100, 4'd8, 1'(o));
      for (int i = 0; i < 12; i++) begin
        sample(s[11 - i]);
        hits[11 - i] = z;
        checks++;
        if (!outputs_ok()) begin
          errors++;
          $display("FAIL long%0d bit%0d: z=%0b cnt=%0d, want z=%0b cnt=%0d", o, i, z, match_cnt, exp_z, m_cnt);
        end
      end
      checks++;
      if (hits !== (o ? 12'b0000_0001_0001 : 12'b0000_0001_0000)) begin
        errors++;
        $display("FAIL long%0d_hits: got %b want %b", o, hits, o ? 12'b0000_0001_0001 : 12'b0000_0001_0000);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bit r, l;
      r = ($urandom_range(0, 149) == 0);
      l = ($urandom_range(0, 39) == 0);
      if (l) begin
        pat_in = 8'($urandom);
        len_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
        ovl_in = 1'($urandom);
      end
      cycle(r, l, ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 29) == 0));
      checks++;
      if (!outputs_ok()) begin
        errors++;
        $display("FAIL random cyc%0d: z=%0b cnt=%0d z2=%0b cnt2=%0d, want z=%0b cnt=%0d cnt2=%0d",
                 i, z, match_cnt, z2, cnt2, exp_z, m_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; x = 1'b0; load = 1'b0; cnt_clr = 1'b0;
    pat_in = '0; len_in = '0; ovl_in = 1'b0;
    test_reset();
    test_default_pattern();
    test_overlap();
    test_en_gaps();
    test_midstream();
    test_len_clamp();
    test_saturation();
    test_cnt_clr();
    test_long_pattern();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
